// File: rtl/rs_multi_issue_if.sv
// Dispatch / wakeup / issue bundle of the multi-issue reservation station.
// master drives dispatch, CDB and FU-ready; slave is the station itself.
interface rs_multi_issue_if #(
  parameter int DEPTH      = 16,
  parameter int PREG_WIDTH = 6,
  parameter int ROB_WIDTH  = 6,
  parameter int NUM_FU     = 3,
  parameter int NUM_CDB    = 2,
  parameter int PAYLOAD_W  = 64,
  parameter int FU_W       = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  parameter int CNT_W      = $clog2(DEPTH + 1)
);
  logic                            flush;
  logic                            disp_valid;
  logic                            disp_ready;
  logic [PAYLOAD_W-1:0]            disp_payload;
  logic [PREG_WIDTH-1:0]           disp_rd;
  logic [PREG_WIDTH-1:0]           disp_src1;
  logic [PREG_WIDTH-1:0]           disp_src2;
  logic [31:0]                     disp_data1;
  logic [31:0]                     disp_data2;
  logic                            disp_rdy1;
  logic                            disp_rdy2;
  logic [FU_W-1:0]                 disp_fu;
  logic [ROB_WIDTH-1:0]            disp_rob;
  logic [NUM_CDB-1:0]              cdb_valid;
  logic [NUM_CDB*PREG_WIDTH-1:0]   cdb_tag;
  logic [NUM_CDB*32-1:0]           cdb_data;
  logic [NUM_FU-1:0]               fu_ready;
  logic [NUM_FU-1:0]               iss_valid;
  logic [NUM_FU*PAYLOAD_W-1:0]     iss_payload;
  logic [NUM_FU*PREG_WIDTH-1:0]    iss_rd;
  logic [NUM_FU*32-1:0]            iss_data1;
  logic [NUM_FU*32-1:0]            iss_data2;
  logic [NUM_FU*ROB_WIDTH-1:0]     iss_rob;
  logic [CNT_W-1:0]                count;

  modport master (
    output flush, disp_valid, disp_payload, disp_rd, disp_src1, disp_src2,
           disp_data1, disp_data2, disp_rdy1, disp_rdy2, disp_fu, disp_rob,
           cdb_valid, cdb_tag, cdb_data, fu_ready,
    input  disp_ready, iss_valid, iss_payload, iss_rd, iss_data1, iss_data2,
           iss_rob, count
  );

  modport slave (
    input  flush, disp_valid, disp_payload, disp_rd, disp_src1, disp_src2,
           disp_data1, disp_data2, disp_rdy1, disp_rdy2, disp_fu, disp_rob,
           cdb_valid, cdb_tag, cdb_data, fu_ready,
    output disp_ready, iss_valid, iss_payload, iss_rd, iss_data1, iss_data2,
           iss_rob, count
  );
endinterface

// File: rtl/rs_multi_issue.sv
// Multi-issue reservation station: CDB wakeup, oldest-first select per FU.
// Define RS_CDB_BYPASS_EN to let a same-cycle CDB hit make an entry eligible.
module rs_multi_issue #(
  parameter int DEPTH      = 16,
  parameter int PREG_WIDTH = 6,
  parameter int ROB_WIDTH  = 6,
  parameter int NUM_FU     = 3,
  parameter int NUM_CDB    = 2,
  parameter int PAYLOAD_W  = 64
) (
  input logic             clk,
  input logic             rst,
  rs_multi_issue_if.slave bus
);
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = ROB_WIDTH + 1;

  // {hit, data}; lowest channel index wins because it is visited last
  function automatic logic [32:0] cdb_lookup(
    input logic [PREG_WIDTH-1:0]         tag,
    input logic [NUM_CDB-1:0]            vld,
    input logic [NUM_CDB*PREG_WIDTH-1:0] tags,
    input logic [NUM_CDB*32-1:0]         data
  );
    logic [32:0] res;
    res = 33'd0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (vld[c] && (tags[c*PREG_WIDTH +: PREG_WIDTH] == tag)) begin
        res = {1'b1, data[c*32 +: 32]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic is_older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
    logic [AGE_W-1:0] diff;
    diff = a - b;
    return diff[AGE_W-1];
  endfunction

  logic [DEPTH-1:0]      valid_r, rdy1_r, rdy2_r;
  logic [PAYLOAD_W-1:0]  payload_r [DEPTH];
  logic [PREG_WIDTH-1:0] rd_r      [DEPTH];
  logic [PREG_WIDTH-1:0] src1_r    [DEPTH];
  logic [PREG_WIDTH-1:0] src2_r    [DEPTH];
  logic [31:0]           data1_r   [DEPTH];
  logic [31:0]           data2_r   [DEPTH];
  logic [FU_W-1:0]       fu_r      [DEPTH];
  logic [ROB_WIDTH-1:0]  rob_r     [DEPTH];
  logic [AGE_W-1:0]      age_r     [DEPTH];
  logic [AGE_W-1:0]      seq_r;
  logic [CNT_W-1:0]      count_r;

  logic [NUM_FU-1:0]             iss_valid_r;
  logic [NUM_FU*PAYLOAD_W-1:0]   iss_payload_r;
  logic [NUM_FU*PREG_WIDTH-1:0]  iss_rd_r;
  logic [NUM_FU*32-1:0]          iss_data1_r, iss_data2_r;
  logic [NUM_FU*ROB_WIDTH-1:0]   iss_rob_r;

  logic [32:0]      hit1_s [DEPTH];
  logic [32:0]      hit2_s [DEPTH];
  logic [DEPTH-1:0] wake1_s, wake2_s, rdy1_eff_s, rdy2_eff_s;
  logic [31:0]      opnd1_s [DEPTH];
  logic [31:0]      opnd2_s [DEPTH];

  logic [DEPTH-1:0] elig_s    [NUM_FU];
  logic [NUM_FU-1:0] sel_vld_s;
  logic [IDX_W-1:0] sel_idx_s [NUM_FU];
  logic [AGE_W-1:0] sel_age_s [NUM_FU];
  logic [DEPTH-1:0] iss_mask_s;
  logic [CNT_W-1:0] iss_cnt_s;

  logic             free_vld_s;
  logic [IDX_W-1:0] free_idx_s;
  logic             disp_ready_s, disp_fire_s;
  logic [32:0]      dhit1_s, dhit2_s;
  logic [CNT_W-1:0] count_nxt_s;

  // CDB tag match per waiting source, and the operand view seen by select
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hit1_s[i]  = cdb_lookup(src1_r[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      hit2_s[i]  = cdb_lookup(src2_r[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      wake1_s[i] = valid_r[i] & ~rdy1_r[i] & hit1_s[i][32];
      wake2_s[i] = valid_r[i] & ~rdy2_r[i] & hit2_s[i][32];
`ifdef RS_CDB_BYPASS_EN
      rdy1_eff_s[i] = rdy1_r[i] | wake1_s[i];
      rdy2_eff_s[i] = rdy2_r[i] | wake2_s[i];
      opnd1_s[i]    = rdy1_r[i] ? data1_r[i] : hit1_s[i][31:0];
      opnd2_s[i]    = rdy2_r[i] ? data2_r[i] : hit2_s[i][31:0];
`else
      rdy1_eff_s[i] = rdy1_r[i];
      rdy2_eff_s[i] = rdy2_r[i];
      opnd1_s[i]    = data1_r[i];
      opnd2_s[i]    = data2_r[i];
`endif
    end
  end

  // Oldest eligible entry per FU (modulo age compare)
  always_comb begin
    iss_mask_s = '0;
    iss_cnt_s  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sel_vld_s[k] = 1'b0;
      sel_idx_s[k] = '0;
      sel_age_s[k] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        elig_s[k][i] = valid_r[i] & rdy1_eff_s[i] & rdy2_eff_s[i]
                     & (fu_r[i] == FU_W'(k)) & bus.fu_ready[k];
        if (elig_s[k][i] && (!sel_vld_s[k] || is_older(age_r[i], sel_age_s[k]))) begin
          sel_vld_s[k] = 1'b1;
          sel_idx_s[k] = IDX_W'(i);
          sel_age_s[k] = age_r[i];
        end else begin
          sel_vld_s[k] = sel_vld_s[k];
        end
      end
      if (sel_vld_s[k]) begin
        iss_mask_s[sel_idx_s[k]] = 1'b1;
      end else begin
        iss_mask_s = iss_mask_s;
      end
      iss_cnt_s = iss_cnt_s + CNT_W'(sel_vld_s[k]);
    end
  end

  // Lowest free slot, dispatch acceptance and same-cycle operand capture
  always_comb begin
    free_vld_s = 1'b0;
    free_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_r[i]) begin
        free_vld_s = 1'b1;
        free_idx_s = IDX_W'(i);
      end else begin
        free_vld_s = free_vld_s;
      end
    end
    disp_ready_s = (count_r < CNT_W'(DEPTH));
    disp_fire_s  = bus.disp_valid & disp_ready_s & ~bus.flush & free_vld_s;
    dhit1_s      = cdb_lookup(bus.disp_src1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    dhit2_s      = cdb_lookup(bus.disp_src2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    count_nxt_s  = count_r + CNT_W'(disp_fire_s) - iss_cnt_s;
  end

  // Entry array: wakeup, free on issue, write on dispatch
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_r <= '0;
      rdy1_r  <= '0;
      rdy2_r  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake1_s[i]) begin
          rdy1_r[i]  <= 1'b1;
          data1_r[i] <= hit1_s[i][31:0];
        end
        if (wake2_s[i]) begin
          rdy2_r[i]  <= 1'b1;
          data2_r[i] <= hit2_s[i][31:0];
        end
        if (iss_mask_s[i]) begin
          valid_r[i] <= 1'b0;
        end
      end
      if (disp_fire_s) begin
        valid_r[free_idx_s]   <= 1'b1;
        payload_r[free_idx_s] <= bus.disp_payload;
        rd_r[free_idx_s]      <= bus.disp_rd;
        src1_r[free_idx_s]    <= bus.disp_src1;
        src2_r[free_idx_s]    <= bus.disp_src2;
        rdy1_r[free_idx_s]    <= bus.disp_rdy1 | dhit1_s[32];
        rdy2_r[free_idx_s]    <= bus.disp_rdy2 | dhit2_s[32];
        data1_r[free_idx_s]   <= bus.disp_rdy1 ? bus.disp_data1 : dhit1_s[31:0];
        data2_r[free_idx_s]   <= bus.disp_rdy2 ? bus.disp_data2 : dhit2_s[31:0];
        fu_r[free_idx_s]      <= bus.disp_fu;
        rob_r[free_idx_s]     <= bus.disp_rob;
        age_r[free_idx_s]     <= seq_r;
      end
    end
  end

  // Occupancy and dispatch sequence number (the latter survives flush)
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
      seq_r   <= '0;
    end else if (bus.flush) begin
      count_r <= '0;
    end else begin
      count_r <= count_nxt_s;
      if (disp_fire_s) begin
        seq_r <= seq_r + AGE_W'(1);
      end
    end
  end

  // Issue registers; operand fields hold their last value between issues
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid_r   <= '0;
      iss_payload_r <= '0;
      iss_rd_r      <= '0;
      iss_data1_r   <= '0;
      iss_data2_r   <= '0;
      iss_rob_r     <= '0;
    end else if (bus.flush) begin
      iss_valid_r <= '0;
    end else begin
      iss_valid_r <= sel_vld_s;
      for (int k = 0; k < NUM_FU; k++) begin
        if (sel_vld_s[k]) begin
          iss_payload_r[k*PAYLOAD_W +: PAYLOAD_W] <= payload_r[sel_idx_s[k]];
          iss_rd_r[k*PREG_WIDTH +: PREG_WIDTH]    <= rd_r[sel_idx_s[k]];
          iss_data1_r[k*32 +: 32]                 <= opnd1_s[sel_idx_s[k]];
          iss_data2_r[k*32 +: 32]                 <= opnd2_s[sel_idx_s[k]];
          iss_rob_r[k*ROB_WIDTH +: ROB_WIDTH]     <= rob_r[sel_idx_s[k]];
        end
      end
    end
  end

  assign bus.disp_ready  = disp_ready_s;
  assign bus.count       = count_r;
  assign bus.iss_valid   = iss_valid_r;
  assign bus.iss_payload = iss_payload_r;
  assign bus.iss_rd      = iss_rd_r;
  assign bus.iss_data1   = iss_data1_r;
  assign bus.iss_data2   = iss_data2_r;
  assign bus.iss_rob     = iss_rob_r;
endmodule

// File: tb/tb_rs_multi_issue.sv
// Directed + random bench for rs_multi_issue against an age-ordered queue model.
module tb_rs_multi_issue;
  localparam int DEPTH = 16;
  localparam int NFU   = 3;
  localparam int NCDB  = 2;
`ifdef RS_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_multi_issue_if bus ();
  rs_multi_issue dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [63:0] pl;
    logic [5:0]  rd, s1, s2, rob;
    logic [31:0] d1, d2;
    bit          r1, r2;
    int          fu;
  } ent_t;

  ent_t q[$];  // oldest first
  logic [NFU-1:0]    e_vld;
  logic [NFU*64-1:0] e_pl;
  logic [NFU*6-1:0]  e_rd, e_rob;
  logic [NFU*32-1:0] e_d1, e_d2;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cdb_hit(input logic [5:0] tag, output logic [31:0] d);
    d = 32'd0;
    for (int c = 0; c < NCDB; c++)
      if (bus.cdb_valid[c] && bus.cdb_tag[c*6 +: 6] == tag) begin
        d = bus.cdb_data[c*32 +: 32];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  // Predict the state after the coming rising edge from the current inputs.
  task automatic model_step();
    int n0;
    logic [31:0] d;
    bit ok1, ok2;
    logic [31:0] v1, v2;
    if (rst) begin
      q.delete();
      e_vld = '0; e_pl = '0; e_rd = '0; e_rob = '0; e_d1 = '0; e_d2 = '0;
      return;
    end
    if (bus.flush) begin
      q.delete();
      e_vld = '0;
      return;
    end
    n0 = q.size();
    e_vld = '0;
    for (int k = 0; k < NFU; k++) begin
      if (bus.fu_ready[k]) begin
        for (int j = 0; j < q.size(); j++) begin
          if (q[j].fu != k) continue;
          ok1 = q[j].r1; v1 = q[j].d1;
          ok2 = q[j].r2; v2 = q[j].d2;
          if (BYP && !ok1 && cdb_hit(q[j].s1, d)) begin ok1 = 1'b1; v1 = d; end
          if (BYP && !ok2 && cdb_hit(q[j].s2, d)) begin ok2 = 1'b1; v2 = d; end
          if (ok1 && ok2) begin
            e_vld[k] = 1'b1;
            e_pl[k*64 +: 64] = q[j].pl;
            e_rd[k*6 +: 6]   = q[j].rd;
            e_rob[k*6 +: 6]  = q[j].rob;
            e_d1[k*32 +: 32] = v1;
            e_d2[k*32 +: 32] = v2;
            q.delete(j);
            break;
          end
        end
      end
    end
    foreach (q[j]) begin
      if (!q[j].r1 && cdb_hit(q[j].s1, d)) begin q[j].r1 = 1'b1; q[j].d1 = d; end
      if (!q[j].r2 && cdb_hit(q[j].s2, d)) begin q[j].r2 = 1'b1; q[j].d2 = d; end
    end
    if (bus.disp_valid && n0 < DEPTH) begin
      ent_t e;
      e.pl = bus.disp_payload; e.rd = bus.disp_rd; e.rob = bus.disp_rob;
      e.s1 = bus.disp_src1; e.s2 = bus.disp_src2; e.fu = int'(bus.disp_fu);
      e.r1 = bus.disp_rdy1; e.d1 = bus.disp_data1;
      e.r2 = bus.disp_rdy2; e.d2 = bus.disp_data2;
      if (!e.r1 && cdb_hit(e.s1, d)) begin e.r1 = 1'b1; e.d1 = d; end
      if (!e.r2 && cdb_hit(e.s2, d)) begin e.r2 = 1'b1; e.d2 = d; end
      q.push_back(e);
    end
  endtask

  task automatic check_all();
    chk("count", 192'(bus.count), 192'(q.size()));
    chk("disp_ready", 192'(bus.disp_ready), 192'(q.size() < DEPTH));
    chk("iss_valid", 192'(bus.iss_valid), 192'(e_vld));
    chk("iss_payload", bus.iss_payload, e_pl);
    chk("iss_rd", 192'(bus.iss_rd), 192'(e_rd));
    chk("iss_rob", 192'(bus.iss_rob), 192'(e_rob));
    chk("iss_data1", 192'(bus.iss_data1), 192'(e_d1));
    chk("iss_data2", 192'(bus.iss_data2), 192'(e_d2));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    bus.flush = 1'b0; bus.disp_valid = 1'b0; bus.cdb_valid = '0;
  endtask

  task automatic disp(input int fu, input bit r1, input bit r2,
                      input logic [5:0] s1, input logic [5:0] s2);
    bus.disp_valid   = 1'b1;
    bus.disp_fu      = 2'(fu);
    bus.disp_rdy1    = r1;
    bus.disp_rdy2    = r2;
    bus.disp_src1    = s1;
    bus.disp_src2    = s2;
    bus.disp_data1   = $urandom;
    bus.disp_data2   = $urandom;
    bus.disp_payload = {$urandom, $urandom};
    bus.disp_rd      = 6'($urandom);
    bus.disp_rob     = 6'($urandom);
  endtask

  initial begin
    logic [5:0] rob_a, rob_b;
    int n;
    rst = 1'b1;
    idle();
    bus.fu_ready = '0; bus.cdb_tag = '0; bus.cdb_data = '0;
    disp(0, 1'b1, 1'b1, 6'd0, 6'd0);
    bus.disp_valid = 1'b0;
    cyc(); cyc();
    chk("reset_disp_ready", 192'(bus.disp_ready), 192'(1'b1));
    chk("reset_iss_data1", 192'(bus.iss_data1), 192'(0));
    rst = 1'b0;

    // three all-ready ops, one per FU
    bus.fu_ready = 3'b111;
    for (int f = 0; f < NFU; f++) begin disp(f, 1'b1, 1'b1, 6'd1, 6'd2); cyc(); end
    idle(); cyc(); cyc(); cyc();
    chk("three_ops_drain", 192'(bus.count), 192'(0));

    // fill, overflow attempt, then release the oldest fu0 entry
    bus.fu_ready = 3'b000;
    for (int i = 0; i < 17; i++) begin disp(i % NFU, 1'b1, 1'b1, 6'd3, 6'd4); cyc(); end
    chk("full_count", 192'(bus.count), 192'(16));
    chk("full_ready", 192'(bus.disp_ready), 192'(0));
    idle(); bus.fu_ready = 3'b001; cyc();
    bus.fu_ready = 3'b000; cyc();
    chk("after_free_ready", 192'(bus.disp_ready), 192'(1));
    bus.flush = 1'b1; cyc(); idle();

    // CDB wakeup on channel 1
    bus.fu_ready = 3'b111;
    disp(1, 1'b0, 1'b1, 6'd7, 6'd0); cyc();
    idle(); cyc();
    bus.cdb_valid = 2'b10; bus.cdb_tag = {6'd7, 6'd12}; bus.cdb_data = {32'hDEADBEEF, 32'h0};
    cyc(); idle();
    n = 1;
    while (!bus.iss_valid[1] && n < 4) begin cyc(); n++; end
    chk("wake_latency", 192'(n), BYP ? 192'(1) : 192'(2));
    chk("wake_data1", 192'(bus.iss_data1[63:32]), 192'(32'hDEADBEEF));
    cyc();

    // dispatch-time capture of src2
    disp(2, 1'b1, 1'b0, 6'd0, 6'd5);
    bus.cdb_valid = 2'b01; bus.cdb_tag = {6'd30, 6'd5}; bus.cdb_data = {32'h0, 32'h0BADF00D};
    cyc(); idle(); cyc(); cyc();
    chk("capture_data2", 192'(bus.iss_data2[95:64]), 192'(32'h0BADF00D));
    cyc();
    chk("capture_drain", 192'(bus.count), 192'(0));

    // age order independent of slot index
    bus.fu_ready = 3'b000;
    disp(0, 1'b0, 1'b1, 6'd9, 6'd0); cyc();
    disp(0, 1'b0, 1'b1, 6'd9, 6'd0); cyc();
    disp(2, 1'b1, 1'b1, 6'd0, 6'd0); cyc();
    disp(0, 1'b0, 1'b1, 6'd9, 6'd0); cyc();
    disp(0, 1'b0, 1'b1, 6'd9, 6'd0); cyc();
    disp(0, 1'b1, 1'b1, 6'd0, 6'd0); cyc();
    idle(); bus.fu_ready = 3'b001; cyc();
    bus.fu_ready = 3'b000; disp(1, 1'b1, 1'b1, 6'd0, 6'd0); rob_a = bus.disp_rob; cyc();
    idle(); bus.fu_ready = 3'b100; cyc();
    bus.fu_ready = 3'b000; disp(1, 1'b1, 1'b1, 6'd0, 6'd0); rob_b = bus.disp_rob; cyc();
    idle(); bus.fu_ready = 3'b010; cyc();
    chk("age_first", 192'(bus.iss_rob[11:6]), 192'(rob_a));
    cyc();
    chk("age_second", 192'(bus.iss_rob[11:6]), 192'(rob_b));
    cyc();
    bus.flush = 1'b1; cyc(); idle();

    // flush with a same-cycle dispatch
    bus.fu_ready = 3'b000;
    for (int i = 0; i < 4; i++) begin disp(i % NFU, 1'b1, 1'b1, 6'd0, 6'd0); cyc(); end
    disp(0, 1'b1, 1'b1, 6'd0, 6'd0); bus.flush = 1'b1; cyc();
    idle(); bus.fu_ready = 3'b111; cyc(); cyc();
    chk("flush_count", 192'(bus.count), 192'(0));
    chk("flush_no_issue", 192'(bus.iss_valid), 192'(0));

    // random traffic, flushed periodically to bound age spread
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 3) != 0)
        disp($urandom_range(0, NFU - 1), $urandom_range(0, 1), $urandom_range(0, 1),
             6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
      bus.cdb_valid = 2'($urandom);
      bus.cdb_tag   = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      bus.cdb_data  = {$urandom, $urandom};
      bus.fu_ready  = 3'($urandom);
      bus.flush     = (c % 40 == 39);
      cyc();
    end

    idle(); rst = 1'b1; cyc(); rst = 1'b0; idle(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
